// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency RAM between the IF and MEM pipeline stages
// Define ARB_RR_EN for round-robin on simultaneous requests; default is fixed MEM priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,

  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,

  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  logic [1:0] state;
  logic [3:0] lat_cnt;
  logic       win_mem;
  logic       win_we;
  logic       drop;
  logic       grant;
  logic       pick_mem;
  logic       in_resp;
  logic       capture;
  logic       unused_addr_lsb;

  assign unused_addr_lsb = ^{if_addr[1:0], mem_addr[1:0]};

`ifdef ARB_RR_EN
  logic last_if;

  // On a tie the port not served last wins; a lone requester always wins.
  assign pick_mem = mem_req & (~if_req | last_if);
`else
  assign pick_mem = mem_req;
`endif

  // Grants are decided in IDLE itself, so the grant cycle is the RAM enable cycle.
  assign grant   = ~rst & (state == S_IDLE) & (if_req | mem_req);
  assign in_resp = ~rst & (state == S_RESP);
  assign capture = (state == S_WAIT) & (lat_cnt == 4'd1);

  always_comb begin
    if_gnt    = grant & ~pick_mem;
    mem_gnt   = grant & pick_mem;
    ram_en    = grant;
    ram_we    = grant & pick_mem & mem_we;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant) begin
      if (pick_mem) begin
        ram_addr  = {2'b00, mem_addr[ADDR_W-1:2]};
        ram_wdata = mem_wdata;
      end else begin
        ram_addr  = {2'b00, if_addr[ADDR_W-1:2]};
      end
    end
  end

  assign if_rvalid  = in_resp & ~win_mem & ~drop;
  assign mem_rvalid = in_resp & win_mem;
  assign if_stall   = if_req & ~if_rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lat_cnt   <= 4'd0;
      win_mem   <= 1'b0;
      win_we    <= 1'b0;
      drop      <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
`ifdef ARB_RR_EN
      last_if   <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            win_mem <= pick_mem;
            win_we  <= pick_mem & mem_we;
            drop    <= ~pick_mem & if_flush;
            lat_cnt <= LAT;
            state   <= S_WAIT;
`ifdef ARB_RR_EN
            last_if <= ~pick_mem;
`endif
          end
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (~win_mem & if_flush)
            drop <= 1'b1;
          if (capture) begin
            state <= S_RESP;
            if (win_mem & ~win_we)
              mem_rdata <= ram_rdata;
            // A flush in the capture cycle itself still suppresses the update.
            if (~win_mem & ~drop & ~if_flush)
              if_rdata <= ram_rdata;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter with a 2-cycle RAM model
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: data for an enable in cycle T is on ram_rdata during T+2.
  logic [DATA_W-1:0] ram [0:63];
  logic [DATA_W-1:0] p0, p1;
  logic              ram_loaded = 1'b0;
  logic              unused_tb;
  assign ram_rdata = p1;
  assign unused_tb = ^ram_addr[ADDR_W-1:6];

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'hA500_0000 | 32'(i);
      ram[4] <= 32'hCAFE_0004;
      ram_loaded <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr[5:0]] <= ram_wdata;
      p0 <= ram[ram_addr[5:0]];
    end
    p1 <= p0;
  end

  task automatic next_cycle;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    next_cycle; next_cycle; #1;
    total++; if ({if_gnt, mem_gnt, ram_en, ram_we, if_rvalid, mem_rvalid, if_stall} !== 7'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=0", {if_gnt, mem_gnt, ram_en, ram_we, if_rvalid, mem_rvalid, if_stall});
    end
    total++; if ({ram_addr, ram_wdata} !== 64'h0) begin
      bad++; $display("FAIL reset_ram_bus got=%h exp=0", {ram_addr, ram_wdata});
    end
    total++; if ({if_rdata, mem_rdata} !== 64'h0) begin
      bad++; $display("FAIL reset_rdata got=%h exp=0", {if_rdata, mem_rdata});
    end
    next_cycle; if_req = 1'b1; #1;
    total++; if ({if_gnt, ram_en} !== 2'b00) begin
      bad++; $display("FAIL reset_no_grant got=%b exp=00", {if_gnt, ram_en});
    end
    next_cycle; rst = 1'b0; if_req = 1'b0; #1;
  endtask

  task automatic test_if_read;
    next_cycle; if_req = 1'b1; if_addr = 32'h10; #1;
    total++; if ({if_gnt, mem_gnt, ram_en, ram_we, if_stall} !== 5'b10101 || ram_addr !== 32'd4) begin
      bad++; $display("FAIL if_read_grant got=%b addr=%h exp=10101 addr=4", {if_gnt, mem_gnt, ram_en, ram_we, if_stall}, ram_addr);
    end
    for (int k = 1; k <= 3; k++) begin
      next_cycle; #1;
      total++; if ({ram_en, if_rvalid, if_stall} !== {1'b0, k == 3, k != 3}) begin
        bad++; $display("FAIL if_read_t%0d got=%b exp=%b", k, {ram_en, if_rvalid, if_stall}, {1'b0, k == 3, k != 3});
      end
    end
    total++; if (if_rdata !== 32'hCAFE_0004) begin
      bad++; $display("FAIL if_read_data got=%h exp=cafe0004", if_rdata);
    end
    next_cycle; if_req = 1'b0; #1;
    total++; if ({if_stall, ram_en} !== 2'b00) begin
      bad++; $display("FAIL if_read_idle got=%b exp=00", {if_stall, ram_en});
    end
  endtask

  task automatic test_mem_write_read;
    next_cycle; mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h55; #1;
    total++; if ({mem_gnt, if_gnt, ram_we} !== 3'b101 || ram_addr !== 32'd8 || ram_wdata !== 32'h55) begin
      bad++; $display("FAIL mem_wr_grant got=%b addr=%h wd=%h exp=101 addr=8 wd=55", {mem_gnt, if_gnt, ram_we}, ram_addr, ram_wdata);
    end
    for (int k = 1; k <= 3; k++) begin
      next_cycle; #1;
      total++; if ({ram_en, mem_rvalid} !== {1'b0, k == 3}) begin
        bad++; $display("FAIL mem_wr_t%0d got=%b exp=%b", k, {ram_en, mem_rvalid}, {1'b0, k == 3});
      end
    end
    total++; if (mem_rdata !== 32'h0) begin
      bad++; $display("FAIL mem_wr_rdata_kept got=%h exp=0", mem_rdata);
    end
    next_cycle; mem_we = 1'b0; mem_wdata = '0; #1;
    total++; if ({mem_gnt, ram_we} !== 2'b10 || ram_addr !== 32'd8) begin
      bad++; $display("FAIL mem_rd_grant got=%b addr=%h exp=10 addr=8", {mem_gnt, ram_we}, ram_addr);
    end
    for (int k = 1; k <= 3; k++) begin
      next_cycle; #1;
      total++; if (mem_rvalid !== (k == 3)) begin
        bad++; $display("FAIL mem_rd_t%0d got=%b exp=%b", k, mem_rvalid, k == 3);
      end
    end
    total++; if (mem_rdata !== 32'h55) begin
      bad++; $display("FAIL mem_rd_data got=%h exp=55", mem_rdata);
    end
    next_cycle; mem_req = 1'b0; #1;
  endtask

  task automatic test_arbitration;
    logic [1:0] exp_g, exp_v;
    logic       slot_if;
    next_cycle; rst = 1'b1; #1;
    next_cycle; rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h10; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h20; #1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin next_cycle; #1; end
`ifdef ARB_RR_EN
      slot_if = ((k / 4) % 2) == 1;
`else
      slot_if = 1'b0;
`endif
      exp_g = (k % 4 == 0) ? (slot_if ? 2'b10 : 2'b01) : 2'b00;
      exp_v = (k % 4 == 3) ? (slot_if ? 2'b10 : 2'b01) : 2'b00;
      total++; if ({if_gnt, mem_gnt} !== exp_g) begin
        bad++; $display("FAIL arb_gnt_t%0d got=%b exp=%b", k, {if_gnt, mem_gnt}, exp_g);
      end
      total++; if ({if_rvalid, mem_rvalid} !== exp_v) begin
        bad++; $display("FAIL arb_rvalid_t%0d got=%b exp=%b", k, {if_rvalid, mem_rvalid}, exp_v);
      end
    end
    next_cycle; if_req = 1'b0; mem_req = 1'b0; #1;
    total++; if ({if_gnt, mem_gnt} !== 2'b00) begin
      bad++; $display("FAIL arb_release got=%b exp=00", {if_gnt, mem_gnt});
    end
  endtask

  task automatic test_flush;
    next_cycle; if_req = 1'b1; if_addr = 32'h10; #1;
    next_cycle; next_cycle; next_cycle; #1;
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hCAFE_0004) begin
      bad++; $display("FAIL flush_pre got=%b %h exp=1 cafe0004", if_rvalid, if_rdata);
    end
    next_cycle; if_addr = 32'h14; #1;
    total++; if ({if_gnt, ram_en} !== 2'b11 || ram_addr !== 32'd5) begin
      bad++; $display("FAIL flush_b2b_grant got=%b addr=%h exp=11 addr=5", {if_gnt, ram_en}, ram_addr);
    end
    next_cycle; if_flush = 1'b1; #1;
    total++; if (if_rvalid !== 1'b0) begin
      bad++; $display("FAIL flush_t1 got=%b exp=0", if_rvalid);
    end
    next_cycle; if_flush = 1'b0; #1;
    next_cycle; #1;
    total++; if ({if_rvalid, if_stall} !== 2'b01 || if_rdata !== 32'hCAFE_0004) begin
      bad++; $display("FAIL flush_t3 got=%b %h exp=01 cafe0004", {if_rvalid, if_stall}, if_rdata);
    end
    next_cycle; if_addr = 32'h18; #1;
    total++; if (if_gnt !== 1'b1 || ram_addr !== 32'd6) begin
      bad++; $display("FAIL flush_idle_t4 got=%b addr=%h exp=1 addr=6", if_gnt, ram_addr);
    end
    next_cycle; next_cycle; next_cycle; #1;
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA500_0006) begin
      bad++; $display("FAIL flush_refetch got=%b %h exp=1 a5000006", if_rvalid, if_rdata);
    end
    next_cycle; if_req = 1'b0; #1;
  endtask

  task automatic test_reset_mid;
    next_cycle; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h14; #1;
    total++; if (mem_gnt !== 1'b1) begin
      bad++; $display("FAIL rstmid_grant got=%b exp=1", mem_gnt);
    end
    next_cycle; rst = 1'b1; #1;
    next_cycle; mem_req = 1'b0; #1;
    total++; if ({if_gnt, mem_gnt, ram_en, ram_we, if_rvalid, mem_rvalid, if_stall} !== 7'b0 ||
                 {ram_addr, ram_wdata, if_rdata, mem_rdata} !== 128'h0) begin
      bad++; $display("FAIL rstmid_zero got=%b %h exp=0 0", {if_gnt, mem_gnt, ram_en, ram_we, if_rvalid, mem_rvalid, if_stall},
                      {ram_addr, ram_wdata, if_rdata, mem_rdata});
    end
    next_cycle; rst = 1'b0; if_req = 1'b1; if_addr = 32'h18; #1;
    total++; if (if_gnt !== 1'b1 || ram_addr !== 32'd6) begin
      bad++; $display("FAIL rstmid_if_grant got=%b addr=%h exp=1 addr=6", if_gnt, ram_addr);
    end
    for (int k = 1; k <= 3; k++) begin
      next_cycle; #1;
      total++; if ({mem_rvalid, if_rvalid} !== {1'b0, k == 3}) begin
        bad++; $display("FAIL rstmid_t%0d got=%b exp=%b", k, {mem_rvalid, if_rvalid}, {1'b0, k == 3});
      end
    end
    total++; if (if_rdata !== 32'hA500_0006 || mem_rdata !== 32'h0) begin
      bad++; $display("FAIL rstmid_data got=%h %h exp=a5000006 0", if_rdata, mem_rdata);
    end
    next_cycle; if_req = 1'b0; #1;
  endtask

  initial begin
    test_reset;
    test_if_read;
    test_mem_write_read;
    test_arbitration;
    test_flush;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous RAM between the instruction-fetch stage and the MEM stage of the five-stage pipeline. It accepts level requests from both stages and grants one access at a time. It sequences the fixed-latency RAM access, returns read data or a write acknowledge to the winner, and generates the freeze signal that holds the fetch PC while a fetch is outstanding. A fetch squashed by a taken branch completes on the RAM side, but its data is discarded.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from RAM enable to valid ram_rdata; legal range 1..15

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; level, held until if_rvalid or flush completion
- if_addr  in  ADDR_W  fetch byte address, stable while if_req
- if_flush  in  1  squash current fetch (BrTaken)
- if_gnt  out  1  one-cycle pulse: fetch granted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched word
- if_stall  out  1  freeze PC/IF register
- mem_req  in  1  data request; level, held until mem_rvalid
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  ADDR_W  data byte address
- mem_wdata  in  DATA_W  write data
- mem_gnt  out  1  one-cycle pulse: data access granted
- mem_rvalid  out  1  one-cycle pulse: read data valid / write done
- mem_rdata  out  DATA_W  read word
- ram_en, ram_we  out  1  RAM strobe and write enable
- ram_addr  out  ADDR_W  word address = {2'b00, addr[ADDR_W-1:2]}
- ram_wdata  out  DATA_W  write data to RAM
- ram_rdata  in  DATA_W  RAM read data

## Operation
- FSM states: IDLE, WAIT, RESP. One transaction is outstanding at most.
- IDLE: if any request is pending, arbitrate, pulse the winner's gnt, and drive ram_en=1, ram_addr, ram_we=mem_we&winner==MEM, and ram_wdata for exactly this cycle. Load lat_cnt=MEM_LAT and go to WAIT.
- WAIT: decrement lat_cnt each cycle. When lat_cnt reaches 1, capture ram_rdata into the winner's rdata register. MEM writes skip the capture. Then go to RESP.
- RESP: pulse the winner's rvalid, ignore all requests, and go to IDLE.
- Arbitration without the macro: fixed priority, MEM over IF.
- if_flush: if it is high in any cycle from grant through the capture cycle of an IF transaction, that transaction is marked dropped. A dropped transaction gets no if_rvalid and no if_rdata update, and the FSM still passes through RESP. if_flush has no effect on MEM transactions or in IDLE with no IF grant.
- if_stall = if_req & ~if_rvalid (combinational).
- rdata registers hold their value until the next capture for that port. mem_rdata is unchanged by writes.
- Reset values: state=IDLE, lat_cnt=0, all gnt/rvalid/ram_en/ram_we=0, ram_addr/ram_wdata=0, if_rdata/mem_rdata=0, drop flag=0, rr pointer=IF-last. A reset mid-transaction abandons it, with no rvalid pulse.

## Timing
- Grant at cycle T. ram_rdata is sampled at T+MEM_LAT. rvalid is high at T+MEM_LAT+1. The earliest next grant is T+MEM_LAT+2.
- Throughput: one access per MEM_LAT+2 cycles.
- Requesters deassert or change req in the cycle after rvalid. Requests present during RESP are never granted in RESP.
- gnt and ram_en always coincide and last one cycle.

## Configuration
- ARB_RR_EN defined: round-robin on simultaneous requests. The winner is the port not served last. The rr pointer updates on every grant and resets so that MEM wins the first tie. A lone requester is always granted.
- ARB_RR_EN undefined: fixed MEM priority. The rr pointer logic is absent, and IF may starve under continuous MEM traffic.

## Test plan
- Reset then IF-only read, if_addr=0x10, MEM_LAT=2, RAM word 4 = 0xCAFE0004 -> if_gnt at T, ram_addr=4 at T, if_rvalid at T+3 with if_rdata=0xCAFE0004, if_stall high T..T+2 and low at T+3.
- MEM write mem_addr=0x20, wdata=0x55 and then a read of the same address -> ram_we=1 only on the first grant, mem_rvalid at T+3, second grant at T+4, mem_rdata=0x55 at T+7.
- Simultaneous if_req and mem_req held continuously -> without macro, MEM is granted every 4 cycles and IF never. With ARB_RR_EN, the grants are MEM, IF, MEM, IF at T, T+4, T+8, T+12.
- IF fetch granted at T with if_flush pulsed at T+1 -> ram_en at T, no if_rvalid, if_rdata unchanged, FSM back in IDLE at T+4.
- rst asserted at T+1 of a MEM read -> every output is 0 at T+2, no mem_rvalid, and a fresh IF request is granted on the first cycle after rst falls.
